mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port unified instruction/data memory of the multi-cycle core.
- Requester F is the instruction fetch path; requester D is the load/store path.
- Serialises accesses through a 3-state FSM, drives the memory port, and returns registered read data with a one-cycle done pulse per requester.
- Sits between the multi-cycle controller/datapath and the memory block.

---
 rtl/mem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates the single-port unified instruction/data memory between the
//   instruction fetch path (F) and the load/store path (D) of the multi-cycle
//   core. Each access takes IDLE -> ACCESS -> DONE. The read word is captured
//   into the owner's rdata register, and the owner's done pulse is raised for
//   the DONE cycle.
//
// Parameters
//   WIDTH           address / data width in bits
//   FIXED_PRIORITY  0 = round-robin on simultaneous requests, 1 = D always wins
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset
//   f_req           fetch request, held until f_done
//   f_address       fetch byte address
//   f_rdata         fetched word (registered)
//   f_done          one-cycle pulse, f_rdata valid
//   d_req           data request, held until d_done
//   d_address       data byte address
//   d_write_data    store data
//   d_write         1 = store, 0 = load
//   d_rdata         load result (registered)
//   d_done          one-cycle pulse, data access complete
//   busy            high whenever the FSM is not IDLE
//   mem_address     memory address (zero outside ACCESS)
//   mem_write_data  memory write data (zero outside ACCESS)
//   mem_write       memory write strobe (only ever high in ACCESS)
//   mem_read_data   combinational memory read of mem_address
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WIDTH          = 32,
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_req,
    input  logic [WIDTH-1:0] f_address,
    output logic [WIDTH-1:0] f_rdata,
    output logic             f_done,
    input  logic             d_req,
    input  logic [WIDTH-1:0] d_address,
    input  logic [WIDTH-1:0] d_write_data,
    input  logic             d_write,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_done,
    output logic             busy,
    output logic [WIDTH-1:0] mem_address,
    output logic [WIDTH-1:0] mem_write_data,
    output logic             mem_write,
    input  logic [WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Owner / last-grant encoding: 0 = F, 1 = D.
    localparam logic OWNER_F = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t           state_r;
    state_t           state_next_s;
    logic             owner_r;
    logic             last_grant_r;
    logic             grant_d_s;
    logic             any_req_s;
    logic [WIDTH-1:0] f_rdata_r;
    logic [WIDTH-1:0] d_rdata_r;
    logic             f_done_r;
    logic             d_done_r;

    assign any_req_s = f_req | d_req;

    // Grant decision for the IDLE cycle; only used when a request is present.
    always_comb begin
        grant_d_s = OWNER_F;
        if (f_req && d_req) begin
            if (FIXED_PRIORITY) begin
                grant_d_s = OWNER_D;
            end else begin
                // Round-robin: the requester that was not granted last wins.
                grant_d_s = (last_grant_r == OWNER_F) ? OWNER_D : OWNER_F;
            end
        end else if (d_req) begin
            grant_d_s = OWNER_D;
        end else begin
            grant_d_s = OWNER_F;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_ACCESS;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCESS: state_next_s = ST_DONE;
            ST_DONE:   state_next_s = ST_IDLE;
            default:   state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs: memory port is driven only while ACCESS is active, so an
    // asynchronous reset drops mem_write immediately.
    always_comb begin
        mem_address    = {WIDTH{1'b0}};
        mem_write_data = {WIDTH{1'b0}};
        mem_write      = 1'b0;
        case (state_r)
            ST_ACCESS: begin
                mem_write_data = d_write_data;
                if (owner_r == OWNER_D) begin
                    mem_address = d_address;
                    mem_write   = d_write;
                end else begin
                    mem_address = f_address;
                    mem_write   = 1'b0;
                end
            end
            default: begin
                mem_address    = {WIDTH{1'b0}};
                mem_write_data = {WIDTH{1'b0}};
                mem_write      = 1'b0;
            end
        endcase
    end

    // Arbitration bookkeeping: owner and last_grant latch on the IDLE sampling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r      <= OWNER_F;
            last_grant_r <= OWNER_D;
        end else if ((state_r == ST_IDLE) && any_req_s) begin
            owner_r      <= grant_d_s;
            last_grant_r <= grant_d_s;
        end else begin
            owner_r      <= owner_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Read-data capture and done pulses: the closing edge of ACCESS loads the
    // owner's rdata (a store sees the pre-write word) and raises its done for
    // exactly the DONE cycle. rdata is not cleared by done.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_rdata_r <= {WIDTH{1'b0}};
            d_rdata_r <= {WIDTH{1'b0}};
            f_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
        end else if (state_r == ST_ACCESS) begin
            if (owner_r == OWNER_D) begin
                d_rdata_r <= mem_read_data;
                d_done_r  <= 1'b1;
                f_done_r  <= 1'b0;
            end else begin
                f_rdata_r <= mem_read_data;
                f_done_r  <= 1'b1;
                d_done_r  <= 1'b0;
            end
        end else begin
            f_done_r <= 1'b0;
            d_done_r <= 1'b0;
        end
    end

    assign f_rdata = f_rdata_r;
    assign d_rdata = d_rdata_r;
    assign f_done  = f_done_r;
    assign d_done  = d_done_r;
    assign busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed self-checking bench. Instance a is round-robin, instance b is
//   fixed priority; both share the request inputs and each has its own small
//   word-indexed memory model.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         f_req;
    logic [W-1:0] f_address;
    logic         d_req;
    logic [W-1:0] d_address;
    logic [W-1:0] d_write_data;
    logic         d_write;

    logic [W-1:0] a_f_rdata, a_d_rdata, a_mem_address, a_mem_write_data, a_mem_read_data;
    logic         a_f_done, a_d_done, a_busy, a_mem_write;
    logic [W-1:0] b_f_rdata, b_d_rdata, b_mem_address, b_mem_write_data, b_mem_read_data;
    logic         b_f_done, b_d_done, b_busy, b_mem_write;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] mem_a [0:15] = '{2: 32'hDEADBEEF, 4: 32'hCAFEF00D, 5: 32'h55AA55AA, default: 32'h0};
    logic [W-1:0] mem_b [0:15] = '{2: 32'hDEADBEEF, 4: 32'hCAFEF00D, 5: 32'h55AA55AA, default: 32'h0};

    assign a_mem_read_data = mem_a[a_mem_address[5:2]];
    assign b_mem_read_data = mem_b[b_mem_address[5:2]];

    // Memory model writes.
    always @(posedge clk) begin
        if (a_mem_write) mem_a[a_mem_address[5:2]] <= a_mem_write_data;
        if (b_mem_write) mem_b[b_mem_address[5:2]] <= b_mem_write_data;
    end

    mem_arbiter #(.WIDTH(W), .FIXED_PRIORITY(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_address(f_address), .f_rdata(a_f_rdata), .f_done(a_f_done),
        .d_req(d_req), .d_address(d_address), .d_write_data(d_write_data), .d_write(d_write),
        .d_rdata(a_d_rdata), .d_done(a_d_done), .busy(a_busy),
        .mem_address(a_mem_address), .mem_write_data(a_mem_write_data),
        .mem_write(a_mem_write), .mem_read_data(a_mem_read_data)
    );

    mem_arbiter #(.WIDTH(W), .FIXED_PRIORITY(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_address(f_address), .f_rdata(b_f_rdata), .f_done(b_f_done),
        .d_req(d_req), .d_address(d_address), .d_write_data(d_write_data), .d_write(d_write),
        .d_rdata(b_d_rdata), .d_done(b_d_done), .busy(b_busy),
        .mem_address(b_mem_address), .mem_write_data(b_mem_write_data),
        .mem_write(b_mem_write), .mem_read_data(b_mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b0;
        f_req        = 1'b0;
        f_address    = 32'h0;
        d_req        = 1'b0;
        d_address    = 32'h0;
        d_write_data = 32'h0;
        d_write      = 1'b0;
        tick();
        tick();
        // Reset state.
        check("rst_f_rdata", a_f_rdata, 32'h0);
        check("rst_d_rdata", a_d_rdata, 32'h0);
        check("rst_f_done", {31'h0, a_f_done}, 32'h0);
        check("rst_d_done", {31'h0, a_d_done}, 32'h0);
        check("rst_busy", {31'h0, a_busy}, 32'h0);
        check("rst_mem_addr", a_mem_address, 32'h0);
        reset = 1'b1;

        // Fetch from 0x8.
        f_req = 1'b1; f_address = 32'h8;
        tick();
        check("f_acc_busy", {31'h0, a_busy}, 32'h1);
        check("f_acc_addr", a_mem_address, 32'h8);
        check("f_acc_wr", {31'h0, a_mem_write}, 32'h0);
        check("f_acc_done_early", {31'h0, a_f_done}, 32'h0);
        tick();
        check("f_done", {31'h0, a_f_done}, 32'h1);
        check("f_rdata", a_f_rdata, 32'hDEADBEEF);
        check("f_done_addr0", a_mem_address, 32'h0);
        check("f_done_wr", {31'h0, a_mem_write}, 32'h0);
        f_req = 1'b0;
        tick();
        check("f_idle_done", {31'h0, a_f_done}, 32'h0);
        check("f_idle_busy", {31'h0, a_busy}, 32'h0);
        check("f_rdata_hold", a_f_rdata, 32'hDEADBEEF);

        // Store 0x12345678 to 0x10 (old word 0xCAFEF00D).
        d_req = 1'b1; d_write = 1'b1; d_address = 32'h10; d_write_data = 32'h12345678;
        check("st_idle_wr", {31'h0, a_mem_write}, 32'h0);
        tick();
        check("st_acc_wr", {31'h0, a_mem_write}, 32'h1);
        check("st_acc_addr", a_mem_address, 32'h10);
        check("st_acc_wdata", a_mem_write_data, 32'h12345678);
        tick();
        check("st_done", {31'h0, a_d_done}, 32'h1);
        check("st_done_wr", {31'h0, a_mem_write}, 32'h0);
        check("st_prewrite", a_d_rdata, 32'hCAFEF00D);
        d_req = 1'b0;
        tick();
        check("st_idle_done", {31'h0, a_d_done}, 32'h0);

        // Load back from 0x10.
        d_req = 1'b1; d_write = 1'b0;
        tick();
        check("ld_acc_wr", {31'h0, a_mem_write}, 32'h0);
        tick();
        check("ld_done", {31'h0, a_d_done}, 32'h1);
        check("ld_rdata", a_d_rdata, 32'h12345678);
        check("ld_f_hold", a_f_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();

        // Both requesting for 12 cycles: round-robin F,D,F,D; fixed priority D only.
        f_req = 1'b1; f_address = 32'h8;
        d_req = 1'b1; d_address = 32'h10; d_write = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("rr_f_done_%0d", k), {31'h0, a_f_done}, {31'h0, (k == 2 || k == 8)});
            check($sformatf("rr_d_done_%0d", k), {31'h0, a_d_done}, {31'h0, (k == 5 || k == 11)});
            check($sformatf("rr_busy_%0d", k), {31'h0, a_busy}, {31'h0, (k % 3 != 0)});
            check($sformatf("fp_f_done_%0d", k), {31'h0, b_f_done}, 32'h0);
            check($sformatf("fp_d_done_%0d", k), {31'h0, b_d_done}, {31'h0, (k % 3 == 2)});
            check($sformatf("fp_busy_%0d", k), {31'h0, b_busy}, {31'h0, (k % 3 != 0)});
        end
        f_req = 1'b0; d_req = 1'b0;
        tick();
        check("rr_quiet_busy", {31'h0, a_busy}, 32'h0);

        // Reset during a store's ACCESS to 0x14.
        d_req = 1'b1; d_write = 1'b1; d_address = 32'h14; d_write_data = 32'hA5A5A5A5;
        tick();
        check("ab_acc_wr", {31'h0, a_mem_write}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("ab_async_wr", {31'h0, a_mem_write}, 32'h0);
        check("ab_async_busy", {31'h0, a_busy}, 32'h0);
        check("ab_async_drd", a_d_rdata, 32'h0);
        check("ab_async_frd", a_f_rdata, 32'h0);
        tick();
        check("ab_no_done", {31'h0, a_d_done}, 32'h0);
        check("ab_rst_wr", {31'h0, a_mem_write}, 32'h0);
        d_write = 1'b0; f_req = 1'b1; f_address = 32'h8;
        reset = 1'b1;
        tick();
        check("ab_grant_f", a_mem_address, 32'h8);
        tick();
        check("ab_f_done", {31'h0, a_f_done}, 32'h1);
        check("ab_f_rdata", a_f_rdata, 32'hDEADBEEF);
        f_req = 1'b0;
        tick();
        tick();
        check("ab_d_acc_addr", a_mem_address, 32'h14);
        // F arrives during D's ACCESS.
        f_req = 1'b1;
        tick();
        check("late_d_done", {31'h0, a_d_done}, 32'h1);
        check("late_no_write", a_d_rdata, 32'h55AA55AA);
        check("late_f_wait", {31'h0, a_f_done}, 32'h0);
        d_req = 1'b0;
        tick();
        check("late_idle", {31'h0, a_busy}, 32'h0);
        tick();
        check("late_f_acc", a_mem_address, 32'h8);
        tick();
        check("late_f_done", {31'h0, a_f_done}, 32'h1);
        check("late_d_hold", a_d_rdata, 32'h55AA55AA);
        f_req = 1'b0;
        tick();
        check("late_f_drop", {31'h0, a_f_done}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
